// File: rtl/fault_sim_monitor.sv
// Response-side controller for LBIST fault simulation: compares faulty vs fault-free
// CUT responses per pattern, paces the pattern generator and tallies detected faults.
module fault_sim_monitor #(
  parameter int OUT_BITS = 25,
  parameter int PAT_BITS = 16,
  parameter int CNT_BITS = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [PAT_BITS-1:0] PAT_MAX,
  input  logic [OUT_BITS-1:0] CUT_OP,
  input  logic [OUT_BITS-1:0] FF_OP,
  input  logic                FIL_END,
  output logic                FIL_INC,
  output logic                pat_adv,
  output logic [CNT_BITS-1:0] FAULTS_TOTAL,
  output logic [CNT_BITS-1:0] FAULTS_DET,
  output logic                busy,
  output logic                done
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SETTLE  = 3'd1;
  localparam logic [2:0] ST_COMPARE = 3'd2;
  localparam logic [2:0] ST_INC     = 3'd3;
  localparam logic [2:0] ST_WAIT    = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;

  localparam logic [PAT_BITS-1:0] PAT_ONE = PAT_BITS'(1);
  localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);

  logic [2:0]          state_q, state_d;
  logic [PAT_BITS-1:0] pat_cnt_q, pat_cnt_d;
  logic [PAT_BITS-1:0] pat_max_q, pat_max_d;
  logic [CNT_BITS-1:0] total_q, total_d;
  logic [CNT_BITS-1:0] det_q, det_d;
  logic                pat_adv_q, pat_adv_d;

  logic mismatch;
  logic last_pat;
  logic total_sat;
  logic det_sat;

  always_comb begin
    mismatch  = (CUT_OP != FF_OP);
    last_pat  = (pat_cnt_q == (pat_max_q - PAT_ONE));
    total_sat = &total_q;
    det_sat   = &det_q;
  end

  // Every COMPARE cycle advances the generator; the registered pulse lands in the
  // following SETTLE or INC cycle, keeping CUT_OP/FF_OP off the output path.
  always_comb begin
    state_d   = state_q;
    pat_cnt_d = pat_cnt_q;
    pat_max_d = pat_max_q;
    total_d   = total_q;
    det_d     = det_q;
    pat_adv_d = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          total_d   = '0;
          det_d     = '0;
          pat_cnt_d = '0;
          pat_max_d = (PAT_MAX == '0) ? PAT_ONE : PAT_MAX;
          state_d   = FIL_END ? ST_DONE : ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        state_d = ST_COMPARE;
      end
      ST_COMPARE: begin
        pat_adv_d = 1'b1;
        if (mismatch) begin
          total_d = total_sat ? total_q : total_q + CNT_ONE;
          det_d   = det_sat ? det_q : det_q + CNT_ONE;
          state_d = ST_INC;
        end else if (last_pat) begin
          total_d = total_sat ? total_q : total_q + CNT_ONE;
          state_d = ST_INC;
        end else begin
          pat_cnt_d = pat_cnt_q + PAT_ONE;
          state_d   = ST_SETTLE;
        end
      end
      ST_INC: begin
        pat_cnt_d = '0;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        state_d = FIL_END ? ST_DONE : ST_SETTLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pat_cnt_q <= '0;
      pat_max_q <= PAT_ONE;
      total_q   <= '0;
      det_q     <= '0;
      pat_adv_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pat_cnt_q <= pat_cnt_d;
      pat_max_q <= pat_max_d;
      total_q   <= total_d;
      det_q     <= det_d;
      pat_adv_q <= pat_adv_d;
    end
  end

  always_comb begin
    FIL_INC      = (state_q == ST_INC);
    pat_adv      = pat_adv_q;
    FAULTS_TOTAL = total_q;
    FAULTS_DET   = det_q;
    busy         = (state_q != ST_IDLE) && (state_q != ST_DONE);
    done         = (state_q == ST_DONE);
  end

endmodule

// File: tb/tb_fault_sim_monitor.sv
// Self-checking bench for fault_sim_monitor: models the fault list and pattern
// generator, and predicts tallies, pacing and timing per fault campaign.
module tb_fault_sim_monitor;

  localparam int OUT_BITS = 25;
  localparam int PAT_BITS = 16;
  localparam int NEVER    = 999;

  logic                clk;
  logic                rst;
  logic                start;
  logic [PAT_BITS-1:0] PAT_MAX;
  logic [OUT_BITS-1:0] CUT_OP;
  logic [OUT_BITS-1:0] FF_OP;
  logic                FIL_END;

  logic        FIL_INC, pat_adv, busy, done;
  logic [15:0] FAULTS_TOTAL, FAULTS_DET;
  logic        fil_inc_s, pat_adv_s, busy_s, done_s;
  logic [1:0]  total_s, det_s;

  int checks = 0;
  int errors = 0;
  int det_pat[16];
  int n_cur;
  int f;
  int p;

  fault_sim_monitor #(.OUT_BITS(OUT_BITS), .PAT_BITS(PAT_BITS), .CNT_BITS(16)) dut (
    .clk(clk), .rst(rst), .start(start), .PAT_MAX(PAT_MAX),
    .CUT_OP(CUT_OP), .FF_OP(FF_OP), .FIL_END(FIL_END),
    .FIL_INC(FIL_INC), .pat_adv(pat_adv),
    .FAULTS_TOTAL(FAULTS_TOTAL), .FAULTS_DET(FAULTS_DET),
    .busy(busy), .done(done)
  );

  fault_sim_monitor #(.OUT_BITS(OUT_BITS), .PAT_BITS(PAT_BITS), .CNT_BITS(2)) dut_small (
    .clk(clk), .rst(rst), .start(start), .PAT_MAX(PAT_MAX),
    .CUT_OP(CUT_OP), .FF_OP(FF_OP), .FIL_END(FIL_END),
    .FIL_INC(fil_inc_s), .pat_adv(pat_adv_s),
    .FAULTS_TOTAL(total_s), .FAULTS_DET(det_s),
    .busy(busy_s), .done(done_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  function automatic int sat(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  // Fault list / pattern generator model: fault f mismatches only on pattern det_pat[f].
  task automatic drive();
    logic [OUT_BITS-1:0] ff;
    logic [OUT_BITS-1:0] m;
    ff = OUT_BITS'($urandom);
    m  = '0;
    if (f < n_cur && p == det_pat[f]) begin
      if ($urandom_range(0, 1) == 1) m = OUT_BITS'(1) << $urandom_range(0, OUT_BITS - 1);
      else m = OUT_BITS'($urandom) | OUT_BITS'(1);
    end
    FF_OP   = ff;
    CUT_OP  = ff ^ m;
    FIL_END = (f >= n_cur);
  endtask

  task automatic advanceModel(input logic fi, input logic pa);
    if (fi) begin
      f++;
      p = 0;
    end else if (pa) begin
      p++;
    end
  endtask

  task automatic applyStimulus(input int n, input int pm_in, input bit noisy);
    int  pm, exp_cycles, exp_adv, run_total, run_det;
    int  busy_cyc, adv_cnt, inc_cnt, cyc;
    bit  saw_done, hit;
    logic fi, pa, bz;
    pm = (pm_in == 0) ? 1 : pm_in;
    exp_cycles = 0;
    exp_adv    = 0;
    for (int i = 0; i < n; i++) begin
      hit = (det_pat[i] < pm);
      exp_cycles += hit ? (2 * det_pat[i] + 4) : (2 * pm + 2);
      exp_adv    += hit ? (det_pat[i] + 1) : pm;
    end
    n_cur = n; f = 0; p = 0;
    run_total = 0; run_det = 0;
    busy_cyc = 0; adv_cnt = 0; inc_cnt = 0; cyc = 0; saw_done = 0;
    @(posedge clk); #1;
    start = 1'b1;
    PAT_MAX = PAT_BITS'(pm_in);
    drive();
    @(posedge clk); #1;
    start = 1'b0;
    drive();
    while (!saw_done && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      bz = busy;
      if (cyc == 1 && n > 0) begin
        checkOutput("busy_rise", busy, 1);
        checkOutput("tally_clear", FAULTS_TOTAL, 0);
      end
      if (done) saw_done = 1;
      else begin
        if (busy) busy_cyc++;
        if (pat_adv) adv_cnt++;
        if (FIL_INC) begin
          inc_cnt++;
          run_total++;
          if (f < n && det_pat[f] < pm) run_det++;
          checkOutput("pat_adv_with_inc", pat_adv, 1);
          checkOutput("total_at_inc", FAULTS_TOTAL, sat(run_total, 65535));
          checkOutput("det_at_inc", FAULTS_DET, sat(run_det, 65535));
          checkOutput("total_small_at_inc", total_s, sat(run_total, 3));
          checkOutput("det_small_at_inc", det_s, sat(run_det, 3));
        end
      end
      fi = FIL_INC;
      pa = pat_adv;
      @(posedge clk); #1;
      advanceModel(fi, pa);
      start = noisy && bz && !saw_done && (f < n) && ($urandom_range(0, 3) == 0);
      if (noisy) PAT_MAX = PAT_BITS'($urandom);
      drive();
    end
    start = 1'b0;
    checkOutput("done_reached", saw_done, 1);
    checkOutput("done_latency", cyc, exp_cycles + 1);
    checkOutput("busy_cycles", busy_cyc, exp_cycles);
    checkOutput("pat_adv_count", adv_cnt, exp_adv);
    checkOutput("fil_inc_count", inc_cnt, n);
    checkOutput("busy_in_done", busy, 0);
    checkOutput("total_final", FAULTS_TOTAL, sat(n, 65535));
    checkOutput("det_final", FAULTS_DET, sat(run_det, 65535));
    checkOutput("total_small_final", total_s, sat(n, 3));
    checkOutput("det_small_final", det_s, sat(run_det, 3));
  endtask

  task automatic resetMidCampaign();
    int   inc_cnt, cyc;
    logic fi, pa;
    bit   glitch;
    n_cur = 4; f = 0; p = 0;
    for (int i = 0; i < 16; i++) det_pat[i] = NEVER;
    @(posedge clk); #1;
    start = 1'b1;
    PAT_MAX = 16'd3;
    drive();
    @(posedge clk); #1;
    start = 1'b0;
    inc_cnt = 0; cyc = 0;
    while (inc_cnt < 2 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      fi = FIL_INC;
      pa = pat_adv;
      if (fi) inc_cnt++;
      @(posedge clk); #1;
      advanceModel(fi, pa);
      drive();
    end
    checkOutput("rst_reached_fault2", inc_cnt, 2);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("busy_in_settle", busy, 1);
    checkOutput("fil_inc_in_settle", FIL_INC, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_fil_inc", FIL_INC, 0);
    checkOutput("rst_pat_adv", pat_adv, 0);
    checkOutput("rst_total", FAULTS_TOTAL, 0);
    checkOutput("rst_det", FAULTS_DET, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    glitch = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      glitch |= FIL_INC | pat_adv | busy | done;
    end
    checkOutput("idle_after_rst", glitch, 0);
    f = 0; p = 0;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    PAT_MAX = '0;
    n_cur = 0; f = 0; p = 0;
    for (int i = 0; i < 16; i++) det_pat[i] = NEVER;
    drive();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_fil_inc", FIL_INC, 0);
    checkOutput("reset_pat_adv", pat_adv, 0);
    checkOutput("reset_total", FAULTS_TOTAL, 0);
    checkOutput("reset_det", FAULTS_DET, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);

    $display("[TB] all faults undetected, PAT_MAX=4");
    for (int i = 0; i < 16; i++) det_pat[i] = NEVER;
    applyStimulus(3, 4, 0);

    $display("[TB] mismatch on pattern 0, 5 faults");
    for (int i = 0; i < 16; i++) det_pat[i] = 0;
    applyStimulus(5, 4, 0);

    $display("[TB] mismatch on final pattern");
    for (int i = 0; i < 16; i++) det_pat[i] = 3;
    applyStimulus(2, 4, 0);

    $display("[TB] PAT_MAX=0 treated as 1");
    for (int i = 0; i < 16; i++) det_pat[i] = NEVER;
    applyStimulus(3, 0, 0);

    $display("[TB] FIL_END high at start");
    applyStimulus(0, 5, 0);

    $display("[TB] saturation with 6 detected faults");
    for (int i = 0; i < 16; i++) det_pat[i] = $urandom_range(0, 1);
    applyStimulus(6, 2, 0);

    $display("[TB] reset during SETTLE of fault 2");
    resetMidCampaign();

    $display("[TB] randomized campaigns with start and PAT_MAX noise");
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 16; i++) det_pat[i] = $urandom_range(0, 7);
      applyStimulus($urandom_range(1, 8), $urandom_range(0, 6), 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fault_sim_monitor.md
# fault_sim_monitor

Response-side controller for the LBIST fault-simulation section. It compares the faulty-CUT output word against the fault-free output word, once per applied pattern. When a fault is detected, or when its pattern budget is exhausted, it pulses the fault-injection increment. It tallies total and detected faults until the fault list ends. It sits between the mid section (CUT_OP, FF_OP, FIL_END) and the test-pattern generator, which it paces via `pat_adv`.

## Interface
- OUT_BITS, 25, width of CUT_OP / FF_OP
- PAT_BITS, 16, width of pattern counter and PAT_MAX
- CNT_BITS, 16, width of fault tallies
- clk  in  1  rising-edge clock; single clock domain
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a campaign; sampled in IDLE and DONE only
- PAT_MAX  in  PAT_BITS  patterns applied per fault before it is declared undetected; sampled on start; 0 treated as 1
- CUT_OP  in  OUT_BITS  faulty-CUT response
- FF_OP  in  OUT_BITS  fault-free response
- FIL_END  in  1  fault list exhausted (from FIL)
- FIL_INC  out  1  one-cycle pulse: inject next fault
- pat_adv  out  1  one-cycle pulse: generator advances TEST_IP at this edge
- FAULTS_TOTAL  out  CNT_BITS  faults evaluated
- FAULTS_DET  out  CNT_BITS  faults detected (mismatch seen)
- busy  out  1  high in any state except IDLE/DONE
- done  out  1  high in DONE

## Operation
- States: IDLE, SETTLE, COMPARE, INC, WAIT, DONE.
- IDLE:
  - On start: clear tallies and pat_cnt, latch PAT_MAX (0 becomes 1).
  - If FIL_END=1, go to DONE. Otherwise go to SETTLE.
- SETTLE: one cycle for the combinational CUT responses to stabilise; then COMPARE.
- COMPARE:
  - mismatch (CUT_OP != FF_OP, full-width compare): FAULTS_TOTAL+1, FAULTS_DET+1, then INC.
  - Else if pat_cnt == PAT_MAX-1: FAULTS_TOTAL+1 only, then INC.
  - Else: pat_adv=1, pat_cnt+1, then SETTLE.
  - Mismatch takes priority over budget exhaustion on the same cycle.
- INC: FIL_INC=1 and pat_adv=1 for exactly this cycle; pat_cnt cleared; then WAIT.
- WAIT: FIL_INC=0. If FIL_END=1, go to DONE; otherwise SETTLE.
- DONE:
  - Tallies frozen; done=1.
  - start restarts exactly as from IDLE, including clearing the tallies.
- Tallies saturate at 2^CNT_BITS-1; FAULTS_DET never exceeds FAULTS_TOTAL.
- start while busy is ignored.
- PAT_MAX changes mid-campaign are ignored; the latched value applies.
- FIL_END is sampled only in IDLE/DONE on start and in WAIT.

## Timing
- Reset state: IDLE; FIL_INC=0, pat_adv=0, FAULTS_TOTAL=0, FAULTS_DET=0, busy=0, done=0, pat_cnt=0.
- All outputs are registered or decoded from state; no combinational path from CUT_OP/FF_OP to any output.
- Each pattern costs 2 cycles (SETTLE + COMPARE).
- Each fault costs 2 extra cycles (INC + WAIT).
- Undetected fault: 2*PAT_MAX + 2 cycles. Fault detected on pattern k (0-based): 2k + 4 cycles.
- Tallies update on the edge that leaves COMPARE and are visible the cycle INC is entered.
- busy rises the cycle after start is sampled.
- done rises the cycle after FIL_END is sampled in WAIT.
- rst mid-campaign: next cycle is IDLE with all outputs zero. Any in-flight FIL_INC pulse is dropped; the FIL is reset by its own reset.

## Test plan
- Equal words, PAT_MAX=4, FIL_END rises after 3 INC pulses:
  - FAULTS_TOTAL=3, FAULTS_DET=0.
  - 3 FIL_INC pulses, each preceded by 4 COMPARE cycles.
  - pat_adv count = 3*3 + 3 = 12.
  - done after 3*10 = 30 cycles of busy.
- Mismatch forced on pattern 0 of every fault, 5 faults:
  - FAULTS_TOTAL=5, FAULTS_DET=5.
  - Each fault takes 4 cycles.
  - No pat_adv outside INC.
- Mismatch exactly on final pattern (pat_cnt=PAT_MAX-1=3):
  - Counted as detected (FAULTS_DET+1), not undetected.
  - Next cycle is INC.
- PAT_MAX=0 with equal words: behaves as PAT_MAX=1, with one COMPARE per fault. FIL_END high at start: done next cycle, both tallies 0, no FIL_INC.
- CNT_BITS=2 with 6 detected faults: both tallies saturate at 3. rst asserted during SETTLE of fault 2: next cycle IDLE, all outputs 0, FIL_INC never glitches.
- start asserted during COMPARE is ignored; start in DONE restarts the campaign with tallies cleared.
